// File: rtl/pt_ctrl.sv
// -----------------------------------------------------------------------------
// pt_ctrl -- page table access controller with clock-hand victim selection.
//
// Handles one page table access at a time:
//   * hit  : sets the ref bit (and the dirty bit on a store), then reports the
//            entry read at lookup.
//   * miss : sweeps a 6-bit clock hand over the 64 entries. Entries with ref=1
//            get their ref bit cleared. The first valid entry with ref=0 is
//            reported as the eviction victim. 64 consecutive invalid probes end
//            the sweep with no victim.
//
// Optional build macro:
//   PT_CTRL_STATS_EN - adds saturating hit_cnt / fault_cnt outputs.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   req, req_vpn, req_wr       access request (sampled in IDLE only)
//   busy                       high whenever not IDLE
//   done, fault, no_victim     completion pulse plus its status flags
//   ppn                        entry read at lookup (valid on done, fault=0)
//   evict_valid/vpn/dirty      victim report, held until evict_ack
//   evict_ack                  handler has consumed the victim
//   pt_vpn, pt_write,          page table port. pt_dirty_ref = {dirty, ref}
//   pt_dirty_ref               is written to entry pt_vpn when pt_write=1
//   pt_fault, pt_entry         combinational page table read data for pt_vpn
//   hit_cnt, fault_cnt         statistics (PT_CTRL_STATS_EN only)
// -----------------------------------------------------------------------------
module pt_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [5:0]  req_vpn,
    input  logic        req_wr,
    input  logic        evict_ack,
    input  logic        pt_fault,
    input  logic [31:0] pt_entry,
`ifdef PT_CTRL_STATS_EN
    output logic [15:0] hit_cnt,
    output logic [15:0] fault_cnt,
`endif
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] ppn,
    output logic        no_victim,
    output logic        evict_valid,
    output logic [5:0]  evict_vpn,
    output logic        evict_dirty,
    output logic [5:0]  pt_vpn,
    output logic        pt_write,
    output logic [1:0]  pt_dirty_ref
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_UPDATE, S_SCAN, S_CLEAR, S_EVICT, S_DONE
    } state_t;

    state_t      r_state;
    logic [5:0]  r_hand;       // clock hand
    logic [5:0]  r_miss_run;   // consecutive invalid probes in the current sweep
    logic        r_wr;         // latched store flag
    logic [31:0] r_entry;      // entry captured at lookup

    logic w_valid;
    logic w_dirty;
    logic w_ref;

    assign w_valid = pt_entry[31];
    assign w_dirty = pt_entry[30];
    assign w_ref   = pt_entry[29];

    // All outputs are registered: each transition loads the values the
    // destination state must present (pt_vpn, pt_write, evict_*, done ...).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_hand       <= 6'd0;
            r_miss_run   <= 6'd0;
            r_wr         <= 1'b0;
            r_entry      <= 32'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fault        <= 1'b0;
            ppn          <= 32'd0;
            no_victim    <= 1'b0;
            evict_valid  <= 1'b0;
            evict_vpn    <= 6'd0;
            evict_dirty  <= 1'b0;
            pt_vpn       <= 6'd0;
            pt_write     <= 1'b0;
            pt_dirty_ref <= 2'b00;
        end else begin
            done     <= 1'b0;
            pt_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        pt_vpn  <= req_vpn;
                        r_wr    <= req_wr;
                        busy    <= 1'b1;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (!pt_fault) begin
                        r_entry      <= pt_entry;
                        pt_dirty_ref <= {w_dirty | r_wr, 1'b1};
                        pt_write     <= 1'b1;
                        r_state      <= S_UPDATE;
                    end else begin
                        pt_vpn     <= r_hand;
                        r_miss_run <= 6'd0;
                        r_state    <= S_SCAN;
                    end
                end
                S_UPDATE: begin
                    done      <= 1'b1;
                    fault     <= 1'b0;
                    no_victim <= 1'b0;
                    ppn       <= r_entry;
                    r_state   <= S_DONE;
                end
                S_SCAN: begin
                    if (!w_valid) begin
                        // The hand advances on every invalid probe, so after
                        // 64 of them it is back where the sweep started.
                        r_hand <= r_hand + 6'd1;
                        pt_vpn <= r_hand + 6'd1;
                        if (r_miss_run == 6'd63) begin
                            done      <= 1'b1;
                            fault     <= 1'b1;
                            no_victim <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_miss_run <= r_miss_run + 6'd1;
                        end
                    end else if (w_ref) begin
                        // Second chance: clear ref, keep dirty. pt_vpn stays
                        // on the hand entry for the write.
                        pt_dirty_ref <= {w_dirty, 1'b0};
                        pt_write     <= 1'b1;
                        r_miss_run   <= 6'd0;
                        r_state      <= S_CLEAR;
                    end else begin
                        evict_valid <= 1'b1;
                        evict_vpn   <= r_hand;
                        evict_dirty <= w_dirty;
                        r_state     <= S_EVICT;
                    end
                end
                S_CLEAR: begin
                    r_hand  <= r_hand + 6'd1;
                    pt_vpn  <= r_hand + 6'd1;
                    r_state <= S_SCAN;
                end
                S_EVICT: begin
                    if (evict_ack) begin
                        evict_valid <= 1'b0;
                        r_hand      <= r_hand + 6'd1;
                        done        <= 1'b1;
                        fault       <= 1'b1;
                        no_victim   <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PT_CTRL_STATS_EN
    // done and fault are registered together, so fault qualifies this pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt   <= 16'd0;
            fault_cnt <= 16'd0;
        end else if (done) begin
            if (fault) begin
                if (fault_cnt != 16'hFFFF) fault_cnt <= fault_cnt + 16'd1;
            end else begin
                if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pt_ctrl -- directed testbench for pt_ctrl.
// The bench owns a 64-entry page table ({valid, dirty, ref, ...}) that answers
// the controller's combinational reads and applies its writes, and acts as the
// eviction handler. Expected values are hand-derived for each vector.
// -----------------------------------------------------------------------------
module tb_pt_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [5:0]  req_vpn;
    logic        req_wr;
    logic        evict_ack;
    logic        pt_fault;
    logic [31:0] pt_entry;
    logic        busy, done, fault, no_victim;
    logic [31:0] ppn;
    logic        evict_valid, evict_dirty, pt_write;
    logic [5:0]  evict_vpn, pt_vpn;
    logic [1:0]  pt_dirty_ref;
`ifdef PT_CTRL_STATS_EN
    logic [15:0] hit_cnt, fault_cnt;
`endif

    pt_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_vpn      (req_vpn),
        .req_wr       (req_wr),
        .evict_ack    (evict_ack),
        .pt_fault     (pt_fault),
        .pt_entry     (pt_entry),
`ifdef PT_CTRL_STATS_EN
        .hit_cnt      (hit_cnt),
        .fault_cnt    (fault_cnt),
`endif
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .ppn          (ppn),
        .no_victim    (no_victim),
        .evict_valid  (evict_valid),
        .evict_vpn    (evict_vpn),
        .evict_dirty  (evict_dirty),
        .pt_vpn       (pt_vpn),
        .pt_write     (pt_write),
        .pt_dirty_ref (pt_dirty_ref)
    );

    always #5 clk = ~clk;

    logic [31:0] pt_mem [64];
    assign pt_entry = pt_mem[pt_vpn];
    assign pt_fault = ~pt_entry[31];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Initial contents: entries below nvalid valid, dirty=0, ref=0.
    function automatic logic [31:0] entry_init(input int i);
        return 32'h8000_0100 + i * 32'h111;
    endfunction

    task automatic init_mem(input int nvalid);
        for (int i = 0; i < 64; i++)
            pt_mem[i] = (i < nvalid) ? entry_init(i) : 32'h0000_0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Per-access observations (cycle 1 = first cycle after the req sample edge)
    int          done_cyc;
    int          wr_n;
    logic [5:0]  wr_vpn [4];
    logic [1:0]  wr_dr  [4];
    int          wr_cyc [4];
    int          ev_n;
    logic [5:0]  ev_vpn;
    logic        ev_dirty;
    logic        o_fault, o_nv, busy1, done_after, busy_after;
    logic [31:0] o_ppn;

    task automatic access(input logic [5:0] vpn, input logic wr, input int ack_delay);
        done_cyc = 0; wr_n = 0; ev_n = 0; ev_vpn = 6'h3F; ev_dirty = 1'b0;
        o_fault = 1'bx; o_nv = 1'bx; o_ppn = 32'hx; busy1 = 1'b0;
        @(negedge clk);
        req = 1'b1; req_vpn = vpn; req_wr = wr;
        @(posedge clk);
        for (int cyc = 1; cyc <= 400 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                req   = 1'b0;
                busy1 = busy;
            end
            if (pt_write) begin
                if (wr_n < 4) begin
                    wr_vpn[wr_n] = pt_vpn;
                    wr_dr[wr_n]  = pt_dirty_ref;
                    wr_cyc[wr_n] = cyc;
                end
                wr_n++;
                pt_mem[pt_vpn][30:29] = pt_dirty_ref;
            end
            if (evict_valid) begin
                ev_n++;
                ev_vpn    = evict_vpn;
                ev_dirty  = evict_dirty;
                evict_ack = (ev_n > ack_delay);
            end else begin
                evict_ack = 1'b0;
            end
            if (done) begin
                done_cyc = cyc;
                o_fault  = fault;
                o_nv     = no_victim;
                o_ppn    = ppn;
            end
        end
        evict_ack = 1'b0;
        check("done_seen", done_cyc != 0, 1);
        @(negedge clk);
        done_after = done;
        busy_after = busy;
        $display("access vpn=%0d wr=%0b done_cyc=%0d fault=%0b no_victim=%0b ppn=%08h writes=%0d evict_cycles=%0d evict_vpn=%0d",
                 vpn, wr, done_cyc, o_fault, o_nv, o_ppn, wr_n, ev_n, ev_vpn);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = 1'b0; req_vpn = 6'd0; req_wr = 1'b0; evict_ack = 1'b0;
        init_mem(6);
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pt_write", pt_write, 0);
        check("rst_evict_valid", evict_valid, 0);
        check("rst_fault", fault, 0);
        check("rst_no_victim", no_victim, 0);
        check("rst_ppn", ppn, 0);
        reset = 1'b0;

        // Load hit on vpn 2: write 01 in cycle 2, done in cycle 3
        access(6'd2, 1'b0, 0);
        check("hit_busy1", busy1, 1);
        check("hit_wr_n", wr_n, 1);
        check("hit_wr_vpn", wr_vpn[0], 2);
        check("hit_wr_dr", wr_dr[0], 2'b01);
        check("hit_wr_cyc", wr_cyc[0], 2);
        check("hit_done_cyc", done_cyc, 3);
        check("hit_fault", o_fault, 0);
        check("hit_ppn", o_ppn, entry_init(2));
        check("hit_ev_n", ev_n, 0);
        check("hit_done_pulse", done_after, 0);
        check("hit_busy_after", busy_after, 0);
        check("hit_ppn_hold", ppn, entry_init(2));

        // Store vpn 3 sets dirty; a later load keeps it
        access(6'd3, 1'b1, 0);
        check("st_wr_dr", wr_dr[0], 2'b11);
        check("st_ppn", o_ppn, entry_init(3));
        access(6'd3, 1'b0, 0);
        check("ld_wr_dr", wr_dr[0], 2'b11);
        check("ld_ppn", o_ppn, entry_init(3) | 32'h6000_0000);

        // Clock sweep: ref on entry 0 gets cleared, entry 1 is the victim
        do_reset();
        init_mem(6);
        access(6'd0, 1'b0, 0);
        check("sw_hit_dr", wr_dr[0], 2'b01);
        access(6'd10, 1'b0, 2);
        check("sw_wr_n", wr_n, 1);
        check("sw_clr_vpn", wr_vpn[0], 0);
        check("sw_clr_dr", wr_dr[0], 2'b00);
        check("sw_ev_vpn", ev_vpn, 1);
        check("sw_ev_dirty", ev_dirty, 0);
        check("sw_ev_hold", ev_n, 3);
        check("sw_done_cyc", done_cyc, 8);
        check("sw_fault", o_fault, 1);
        check("sw_no_victim", o_nv, 0);
        // Hand is now 2
        pt_mem[3][30] = 1'b1;
        access(6'd11, 1'b0, 0);
        check("h2_ev_vpn", ev_vpn, 2);
        check("h2_wr_n", wr_n, 0);
        access(6'd11, 1'b0, 0);
        check("h3_ev_vpn", ev_vpn, 3);
        check("h3_ev_dirty", ev_dirty, 1);
        access(6'd11, 1'b0, 0);
        check("h4_ev_vpn", ev_vpn, 4);
        access(6'd11, 1'b0, 0);
        check("h5_ev_vpn", ev_vpn, 5);
        // Hand 6..63 invalid (58 probes), wraps to entry 0
        access(6'd11, 1'b0, 0);
        check("wrap_ev_vpn", ev_vpn, 0);
        check("wrap_done_cyc", done_cyc, 62);
        check("wrap_no_victim", o_nv, 0);

        // No valid entry: 64 probes then abort; hand unchanged
        do_reset();
        init_mem(1);
        access(6'd10, 1'b0, 0);
        check("nv_pre_ev_vpn", ev_vpn, 0);
        init_mem(0);
        access(6'd7, 1'b0, 0);
        check("nv_fault", o_fault, 1);
        check("nv_no_victim", o_nv, 1);
        check("nv_ev_n", ev_n, 0);
        check("nv_wr_n", wr_n, 0);
        check("nv_done_cyc", done_cyc, 66);
        init_mem(2);
        access(6'd7, 1'b0, 0);
        check("nv_hand_kept", ev_vpn, 1);
        check("nv_after_no_victim", o_nv, 0);

        // Reset while in EVICT
        do_reset();
        init_mem(6);
        access(6'd10, 1'b0, 0);
        check("re_pre_ev_vpn", ev_vpn, 0);
        @(negedge clk);
        req = 1'b1; req_vpn = 6'd10; req_wr = 1'b0;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 20 && !evict_valid; i++) @(negedge clk);
        check("re_reached_evict", evict_valid, 1);
        check("re_evict_vpn", evict_vpn, 1);
        #1 reset = 1'b1;
        #1;
        check("re_evict_valid", evict_valid, 0);
        check("re_busy", busy, 0);
        check("re_pt_write", pt_write, 0);
        check("re_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        access(6'd10, 1'b0, 0);
        check("re_hand0", ev_vpn, 0);
        check("re_done_cyc", done_cyc, 4);

`ifdef PT_CTRL_STATS_EN
        do_reset();
        init_mem(6);
        check("st_rst_hit", hit_cnt, 0);
        check("st_rst_fault", fault_cnt, 0);
        access(6'd1, 1'b0, 0);
        access(6'd2, 1'b1, 0);
        access(6'd3, 1'b0, 0);
        access(6'd10, 1'b0, 0);
        access(6'd10, 1'b0, 0);
        check("st_hit_cnt", hit_cnt, 3);
        check("st_fault_cnt", fault_cnt, 2);
        force dut.hit_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.hit_cnt;
        access(6'd1, 1'b0, 0);
        check("st_hit_sat", hit_cnt, 16'hFFFF);
        check("st_fault_keep", fault_cnt, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
